// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the word index to the instruction
// port and registers the returned word into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_SYSCALL = 1'b1,
  parameter int          CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_data,
  output logic [31:0]          pc,
  output logic [31:0]          id_instr,
  output logic [31:0]          id_pc_plus4,
  output logic                 id_valid,
  output logic                 halted,
  output logic                 misaligned,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [31:0] SYSCALL = 32'h0000_000C;

  state_t state;

  assign imem_addr = {2'b00, pc[31:2]};
  assign halted    = (state == HALTED);

  // NOTE: every register here uses non-blocking assignment so that all
  // right-hand sides see pre-edge values, matching the hardware's behaviour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      id_instr    <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            id_instr    <= '0;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) misaligned <= 1'b1;
          end else if (!stall) begin
            id_instr    <= imem_data;
            id_pc_plus4 <= pc + 32'd4;
            id_valid    <= 1'b1;
            if (fetch_count != '1) fetch_count <= fetch_count + CNT_WIDTH'(1);
            // A delivered syscall parks the PC on itself and stops fetching.
            if (HALT_ON_SYSCALL && imem_data == SYSCALL) state <= HALTED;
            else                                          pc    <= pc + 32'd4;
          end
        end
        HALTED: begin
          if (!stall) begin
            id_instr    <= '0;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed program scenarios plus a
// randomized run compared every cycle against a behavioural fetch model.
module tb_fetch_stage;

  localparam int          CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;
  localparam logic [31:0] SYS  = 32'h0000_000C;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   pc;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc_plus4;
  logic          id_valid;
  logic          halted;
  logic          misaligned;
  logic [CW-1:0] fetch_count;

  logic [31:0] mem [256];

  assign imem_data = mem[imem_addr[7:0]];

  fetch_stage #(.RESET_PC(32'h0), .HALT_ON_SYSCALL(1'b1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .halted(halted), .misaligned(misaligned), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Behavioural view of the stage: what has been fetched, where fetch points next.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halted, m_mis;
  int          m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = '0; m_pc4 = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0; m_cnt = 0;
  endtask

  task automatic model_bubble();
    m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    if (m_halted) begin
      if (!stall) model_bubble();
    end else if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      model_bubble();
      if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
    end else if (!stall) begin
      w       = mem[m_pc[9:2]];
      m_instr = w;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      if (m_cnt < MAXC) m_cnt++;
      if (w == SYS) m_halted = 1'b1;
      else          m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_model();
    check("pc",          pc,                      m_pc);
    check("imem_addr",   imem_addr,               {2'b00, m_pc[31:2]});
    check("id_instr",    id_instr,                m_instr);
    check("id_pc_plus4", id_pc_plus4,             m_pc4);
    check("id_valid",    32'(id_valid),           32'(m_valid));
    check("halted",      32'(halted),             32'(m_halted));
    check("misaligned",  32'(misaligned),         32'(m_mis));
    check("fetch_count", 32'(fetch_count),        32'(m_cnt));
  endtask

  // Drive inputs (from a negedge), clock once, then compare at the next negedge.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    stall = s; redirect = r; redirect_pc = rpc;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  // Mid-cycle asynchronous reset pulse, released before the next rising edge.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_model();
    check("async pc",    pc,                32'h0);
    check("async count", 32'(fetch_count),  32'h0);
    check("async halt",  32'(halted),       32'h0);
    #1 reset_n = 1'b1;
  endtask

  task automatic fill_mem(input int sys_pct);
    for (int i = 0; i < 256; i++) begin
      if (int'($urandom_range(0, 99)) < sys_pct) mem[i] = SYS;
      else begin
        mem[i] = $urandom;
        if (mem[i] == SYS) mem[i] = 32'h2000_0000;
      end
    end
  endtask

  logic [31:0] r40;

  initial begin
    fill_mem(0);
    mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020; mem[3] = SYS;
    r40 = mem[8'h10];

    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_model();
    check("reset valid", 32'(id_valid), 32'h0);
    check("reset pc",    pc,            32'h0);
    reset_n = 1'b1;

    // Free-run through the four-word program up to the syscall.
    step(0, 0, 0);
    check("p1 instr", id_instr,      32'h2008_0001);
    check("p1 pc4",   id_pc_plus4,   32'h4);
    check("p1 valid", 32'(id_valid), 32'h1);
    step(0, 0, 0);
    check("p2 instr", id_instr, 32'h2009_0002);
    step(0, 0, 0);
    step(0, 0, 0);
    check("p4 instr",  id_instr,    SYS);
    check("p4 halted", 32'(halted), 32'h1);
    check("p4 pc",     pc,          32'hC);
    step(0, 0, 0);
    check("p5 valid", 32'(id_valid),    32'h0);
    check("p5 count", 32'(fetch_count), 32'h4);
    step(0, 1, 32'h80);
    check("halt ignores redirect", pc, 32'hC);

    async_reset();
    step(0, 0, 0);
    check("restart instr", id_instr, 32'h2008_0001);

    // Three stalled cycles right after the first fetch.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      check("stall pc",    pc,               32'h4);
      check("stall instr", id_instr,         32'h2008_0001);
      check("stall count", 32'(fetch_count), 32'h1);
    end
    step(0, 0, 0);
    check("resume instr", id_instr, 32'h2009_0002);

    // Redirect overrides a simultaneous stall.
    step(1, 1, 32'h40);
    check("redir pc",    pc,            32'h40);
    check("redir valid", 32'(id_valid), 32'h0);
    check("redir addr",  imem_addr,     32'h10);
    step(0, 0, 0);
    check("redir instr", id_instr,    r40);
    check("redir pc4",   id_pc_plus4, 32'h44);

    // Misaligned target is word-aligned and leaves a sticky flag.
    step(0, 1, 32'h46);
    check("mis pc",   pc,              32'h44);
    check("mis flag", 32'(misaligned), 32'h1);
    repeat (3) step(0, 0, 0);
    check("mis sticky", 32'(misaligned), 32'h1);

    // PC wraps from the last word to zero.
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    check("wrap pc",  pc,          32'h0);
    check("wrap pc4", id_pc_plus4, 32'h0);

    // Redirect in the syscall's cycle discards it.
    async_reset();
    check("mis cleared", 32'(misaligned), 32'h0);
    repeat (3) step(0, 0, 0);
    step(0, 1, 32'h0);
    check("sysredir pc",    pc,               32'h0);
    check("sysredir valid", 32'(id_valid),    32'h0);
    check("sysredir halt",  32'(halted),      32'h0);
    check("sysredir count", 32'(fetch_count), 32'h3);

    // Randomized traffic, including counter saturation and halts.
    fill_mem(4);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 1) == 0) rpc = $urandom;
      else                           rpc = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 99) < 2) async_reset();
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the unified word-addressed memory's instruction port.
- Holds the PC and drives the instruction word index to the memory.
- Captures the returned word into an IF/ID pipeline register for decode.
- Handles decode stalls, branch/jump redirects and syscall halt; exposes a fetch counter for bring-up of the fib test programs.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
HALT_ON_SYSCALL, 1, when 1 a fetched 32'h0000_000C stops fetching
CNT_WIDTH, 32, width of fetch_count

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold request from decode/hazard logic
redirect  in  1  taken branch/jump this cycle
redirect_pc  in  32  byte-address target for redirect
imem_addr  out  32  word index to memory instruction port = {2'b00, pc[31:2]}
imem_data  in  32  instruction word from memory; combinational read of imem_addr, same cycle
pc  out  32  current fetch PC (byte address)
id_instr  out  32  IF/ID instruction
id_pc_plus4  out  32  IF/ID PC+4 of id_instr
id_valid  out  1  IF/ID holds a real instruction
halted  out  1  fetch stopped on syscall
misaligned  out  1  sticky: a redirect target had nonzero bits [1:0]
fetch_count  out  CNT_WIDTH  instructions delivered to IF/ID, saturating

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-stall or halted):
  - pc=RESET_PC; id_instr=0; id_pc_plus4=0; id_valid=0; halted=0; misaligned=0; fetch_count=0; state=RUN.
- imem_addr is combinational from the pc register only, never from inputs. Instruction latency: PC to id_instr is 1 clock.
- FSM states RUN, HALTED. halted=1 exactly in HALTED.
- RUN, each rising edge, priority redirect > stall > advance:
  - redirect=1:
    - pc <= {redirect_pc[31:2],2'b00}.
    - IF/ID becomes a bubble: id_valid<=0, id_instr<=0, id_pc_plus4<=0.
    - misaligned<=1 if redirect_pc[1:0]!=0, else unchanged.
    - fetch_count unchanged. Overrides stall in the same cycle.
  - stall=1, redirect=0: pc, id_*, fetch_count all hold.
  - advance:
    - id_instr<=imem_data; id_pc_plus4<=pc+4; id_valid<=1; fetch_count+1, saturating at all-ones.
    - pc<=pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Halt: advance with HALT_ON_SYSCALL=1 and imem_data==32'h0000_000C:
    - The syscall is delivered to IF/ID with id_valid=1 and counted.
    - pc holds (not incremented); next state HALTED.
    - A redirect in that cycle wins: no halt, syscall discarded.
- HALTED:
  - pc frozen; redirect and redirect_pc ignored; fetch_count frozen.
  - stall=1 holds IF/ID. stall=0 makes IF/ID a bubble (id_valid<=0, id_instr<=0, id_pc_plus4<=0).
  - Exit only via reset.
- misaligned is cleared only by reset.

Test Plan:
- Reset then free-run, memory words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x0000000C:
  - Posedge 1: id_instr=0x20080001, id_pc_plus4=4, id_valid=1. Posedge 2: id_instr=0x20090002.
  - Posedge 4: syscall delivered, halted=1, pc=0xC. Posedge 5: id_valid=0. fetch_count=4.
- stall high for 3 cycles after first fetch:
  - pc=4 and id_instr=0x20080001 hold all 3 cycles; fetch_count=1 throughout.
  - Resumes with 0x20090002 on the first edge after stall drops.
- redirect=1 and stall=1 together, redirect_pc=0x40:
  - Next edge pc=0x40, id_valid=0, imem_addr=0x10.
  - Following edge loads mem[0x10] with id_pc_plus4=0x44.
- redirect_pc=0x46: pc=0x44, misaligned=1 and stays 1 across later normal fetches until reset.
- Syscall at pc=0xC with redirect=1 to 0x0 in the same cycle: no halt, pc=0, id_valid=0, fetch_count unchanged.
- reset_n pulsed low mid-clock while HALTED with fetch_count=4:
  - All outputs clear immediately without a clock edge: pc=RESET_PC, halted=0, fetch_count=0.
  - Fetch restarts on the first edge after release.
